// File: rtl/kmc_intr_pkg.sv
// kmc_intr_pkg: shared types and constants for the KMC11 interrupt arbiter.
//   state_t   : arbiter FSM states (IDLE, ACT, VECT)
//   VECTA_DEF : default vector for source A (input-ready), 9'o540
//   VECTB_DEF : default vector for source B (output-ready), 9'o544
package kmc_intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACT  = 2'd1,
    ST_VECT = 2'd2
  } state_t;

  localparam logic [8:0] VECTA_DEF = 9'o540;
  localparam logic [8:0] VECTB_DEF = 9'o544;

endpackage

// File: rtl/kmc_intr_pri.sv
// kmc_intr_pri: priority selector for the two KMC11 interrupt sources.
// Build option: KMC_INTR_RR_EN
//   defined   : round-robin; holds the last-serviced pointer (0 = A, 1 = B)
//               and prefers the source not last serviced when both request.
//   undefined : fixed priority, A over B; purely combinational, no pointer.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (round-robin only)
//   upd       : pointer update strobe, one cycle on VECT->IDLE (round-robin only)
//   served    : grant being retired on that exit (round-robin only)
//   req_a/b   : request terms (pending flag OR same-cycle set pulse)
//   gnt_nxt   : selected grant (0 = A, 1 = B); 0 when nothing requests
module kmc_intr_pri (
`ifdef KMC_INTR_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic upd,
  input  logic served,
`endif
  input  logic req_a,
  input  logic req_b,
  output logic gnt_nxt
);

`ifdef KMC_INTR_RR_EN
  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b0;
    end else if (upd) begin
      last <= served;
    end
  end

  // On contention, the source that was not serviced last wins.
  always_comb begin
    gnt_nxt = req_b;
    if (req_a && req_b) begin
      gnt_nxt = ~last;
    end
  end
`else
  always_comb begin
    gnt_nxt = ~req_a & req_b;
  end
`endif

endmodule

// File: rtl/kmc_intr_arb.sv
// kmc_intr_arb: merges the KMC11 RDYI (A) and RDYO (B) interrupt events onto
// the single Unibus request line and supplies the granted vector.
// Build option: KMC_INTR_RR_EN selects round-robin instead of A-over-B
// priority (see kmc_intr_pri).
// Parameters: VECTA, VECTB - vectors for sources A and B.
// Ports:
//   clk         : clock
//   rst         : synchronous active-high reset
//   kmcINIT     : device initialize, same effect as rst
//   kmcSETIRQA/B: one-cycle event pulses
//   kmcIACK     : interrupt acknowledge, high for the whole vector cycle
//   kmcIRQO     : bus interrupt request
//   kmcVECTO    : granted vector, 0 when idle
//   kmcACKA/B   : one-cycle serviced pulses
//   kmcPENDA/B  : pending status flags
//
// state | meaning
// IDLE  | no request on the bus; grant tracks the selector
// ACT   | request asserted; grant tracks the selector until IACK
// VECT  | vector cycle; grant frozen, exit on IACK low retires the grant
module kmc_intr_arb
  import kmc_intr_pkg::*;
#(
  parameter logic [8:0] VECTA = VECTA_DEF,
  parameter logic [8:0] VECTB = VECTB_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kmcINIT,
  input  logic       kmcSETIRQA,
  input  logic       kmcSETIRQB,
  input  logic       kmcIACK,
  output logic       kmcIRQO,
  output logic [8:0] kmcVECTO,
  output logic       kmcACKA,
  output logic       kmcACKB,
  output logic       kmcPENDA,
  output logic       kmcPENDB
);

  state_t state, state_nxt;
  logic   pend_a, pend_b;
  logic   gnt, gnt_nxt;
  logic   ack_a, ack_b;
  logic   exit_vect;
  logic   gnt_upd;
  logic   rst_any;
  logic   req_a, req_b;

  assign rst_any = rst | kmcINIT;
  // Same-cycle set pulses count as requests so IRQO rises one edge after SETIRQ.
  assign req_a   = pend_a | kmcSETIRQA;
  assign req_b   = pend_b | kmcSETIRQB;

  kmc_intr_pri u_pri (
`ifdef KMC_INTR_RR_EN
    .clk     (clk),
    .rst     (rst_any),
    .upd     (exit_vect),
    .served  (gnt),
`endif
    .req_a   (req_a),
    .req_b   (req_b),
    .gnt_nxt (gnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst_any) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    exit_vect = 1'b0;
    gnt_upd   = 1'b0;
    kmcIRQO   = 1'b0;
    kmcVECTO  = 9'o000;
    unique case (state)
      ST_IDLE: begin
        gnt_upd = 1'b1;
        if (req_a || req_b) begin
          state_nxt = ST_ACT;
        end
      end
      ST_ACT: begin
        kmcIRQO  = 1'b1;
        kmcVECTO = gnt ? VECTB : VECTA;
        if (kmcIACK) begin
          state_nxt = ST_VECT;
        end else begin
          gnt_upd = 1'b1;
        end
      end
      ST_VECT: begin
        kmcIRQO  = 1'b1;
        kmcVECTO = gnt ? VECTB : VECTA;
        if (!kmcIACK) begin
          state_nxt = ST_IDLE;
          exit_vect = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // A set pulse on the retiring edge wins over the clear.
  always_ff @(posedge clk) begin
    if (rst_any) begin
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      gnt    <= 1'b0;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
    end else begin
      pend_a <= kmcSETIRQA | (pend_a & ~(exit_vect & ~gnt));
      pend_b <= kmcSETIRQB | (pend_b & ~(exit_vect & gnt));
      ack_a  <= exit_vect & ~gnt;
      ack_b  <= exit_vect & gnt;
      if (gnt_upd) begin
        gnt <= gnt_nxt;
      end
    end
  end

  assign kmcACKA  = ack_a;
  assign kmcACKB  = ack_b;
  assign kmcPENDA = pend_a;
  assign kmcPENDB = pend_b;

endmodule
